// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes active-low columns, samples synchronised rows,
// and debounces whole scan frames into one key_valid pulse per accepted press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned SLOT_W    = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB       = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONFIRM,
    S_HELD,
    S_RELEASE
  } state_e;

  logic [3:0]        rs1_q, rs2_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        col_q, col_d;
  logic [15:0]       frame_q, frame_c;
  logic              sample_c, frame_end_c;
  logic [4:0]        n_keys_c;
  logic [3:0]        hit_key_c;
  logic              single_c, empty_c;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d, cnt_inc_c;
  logic [3:0]        cand_q, cand_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;

  // Legend lookup indexed by (row, column), index 0 = topmost/leftmost.
  function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b0000: key_lut = 4'h1;
      4'b0001: key_lut = 4'h2;
      4'b0010: key_lut = 4'h3;
      4'b0011: key_lut = 4'hA;
      4'b0100: key_lut = 4'h4;
      4'b0101: key_lut = 4'h5;
      4'b0110: key_lut = 4'h6;
      4'b0111: key_lut = 4'hB;
      4'b1000: key_lut = 4'h7;
      4'b1001: key_lut = 4'h8;
      4'b1010: key_lut = 4'h9;
      4'b1011: key_lut = 4'hC;
      4'b1100: key_lut = 4'h0;
      4'b1101: key_lut = 4'hF;
      4'b1110: key_lut = 4'hE;
      default: key_lut = 4'hD;
    endcase
  endfunction

  // Two-flop synchroniser; idle rows read as all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_q <= 4'hF;
      rs2_q <= 4'hF;
    end else begin
      rs1_q <= row;
      rs2_q <= rs1_q;
    end
  end

  assign sample_c    = (slot_q == SLOT_LAST);
  assign frame_end_c = sample_c && (idx_q == 2'd3);

  always_comb begin
    slot_d = sample_c ? '0 : slot_q + SLOT_W'(1);
    idx_d  = sample_c ? idx_q + 2'd1 : idx_q;
    col_d  = ~(4'b0001 << idx_d);
  end

  // Frame snapshot: bits [4c+3:4c] hold the active-low rows seen on column c.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q  <= '0;
      idx_q   <= 2'd0;
      col_q   <= 4'b1110;
      frame_q <= 16'hFFFF;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
      col_q  <= col_d;
      if (sample_c) begin
        frame_q[{idx_q, 2'b00} +: 4] <= rs2_q;
      end
    end
  end

  // The column being sampled this cycle is merged in so frame end sees the full frame.
  always_comb begin
    frame_c = frame_q;
    frame_c[{idx_q, 2'b00} +: 4] = rs2_q;
  end

  always_comb begin
    n_keys_c  = 5'd0;
    hit_key_c = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (!frame_c[i]) begin
        n_keys_c  = n_keys_c + 5'd1;
        hit_key_c = key_lut(2'(i % 4), 2'(i / 4));
      end
    end
  end

  assign single_c  = (n_keys_c == 5'd1);
  assign empty_c   = (n_keys_c == 5'd0);
  assign cnt_inc_c = cnt_q + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Debounce FSM advances only on frame end; a held key never re-triggers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (frame_end_c) begin
      case (state_q)
        S_IDLE: begin
          if (single_c) begin
            if (DEB == 4'd1) begin
              state_d     = S_HELD;
              key_code_d  = hit_key_c;
              key_valid_d = 1'b1;
            end else begin
              state_d = S_CONFIRM;
            end
            cnt_d  = 4'd1;
            cand_d = hit_key_c;
          end
        end
        S_CONFIRM: begin
          if (single_c && (hit_key_c == cand_q)) begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == DEB) begin
              state_d     = S_HELD;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
            end
          end else if (single_c) begin
            cand_d = hit_key_c;
            cnt_d  = 4'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HELD: begin
          if (empty_c) begin
            state_d = (DEB == 4'd1) ? S_IDLE : S_RELEASE;
            cnt_d   = 4'd1;
          end
        end
        S_RELEASE: begin
          if (empty_c) begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == DEB) begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_HELD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    key_held_d = (state_d == S_HELD) || (state_d == S_RELEASE);
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, expected key codes queued at press
// time and matched against each key_valid pulse, plus cycle-exact latency checks.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEBOUNCE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  mon_exp;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Keypad: key (r,c) pulls row r low while column c is strobed.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] kbit(input int r, input int c);
    return 16'd1 << (r*4 + c);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after the edge on which col moves from column 3 back to column 0.
  task automatic sync_frame();
    logic [3:0] prev;
    logic       found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev = col;
      @(posedge clk);
      #1;
      if (prev == 4'b0111 && col == 4'b1110) found = 1'b1;
    end
    check("sync_frame", 32'(found), 32'd1);
  endtask

  // Every key_valid pulse must consume one queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(key_valid), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("valid_code", 32'(key_code), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_col;
    reset   = 1'b1;
    pressed = 16'h0000;
    cyc(3);
    check("reset_col", 32'(col), 32'hE);
    check("reset_valid", 32'(key_valid), 32'd0);
    check("reset_held", 32'(key_held), 32'd0);
    check("reset_code", 32'(key_code), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("col_step", 32'(col), 32'(exp_col));
    end

    // Single press of (1,1) -> '5', cycle-exact acceptance, no repeat, release.
    sync_frame();
    exp_q.push_back(4'h5);
    pressed = kbit(1, 1);
    cyc(31);
    check("press5_early", 32'(key_valid), 32'd0);
    cyc(1);
    check("press5_valid", 32'(key_valid), 32'd1);
    check("press5_code", 32'(key_code), 32'h5);
    check("press5_held", 32'(key_held), 32'd1);
    cyc(1);
    check("press5_width", 32'(key_valid), 32'd0);
    cyc(160);
    check("press5_hold", 32'(key_held), 32'd1);
    sync_frame();
    pressed = 16'h0000;
    cyc(31);
    check("rel5_early", 32'(key_held), 32'd1);
    cyc(1);
    check("rel5_held", 32'(key_held), 32'd0);
    check("rel5_code", 32'(key_code), 32'h5);

    // Asynchronous reset mid-slot, away from any clock edge.
    cyc(5);
    check("pre_reset_col", 32'(col != 4'b1110), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_col", 32'(col), 32'hE);
    check("async_code", 32'(key_code), 32'd0);
    check("async_held", 32'(key_held), 32'd0);
    check("async_valid", 32'(key_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Bounce on (3,1): alternating frames never confirm; steady press gives 'F'.
    sync_frame();
    for (int f = 0; f < 8; f++) begin
      pressed = (f % 2 == 0) ? kbit(3, 1) : 16'h0000;
      cyc(16);
    end
    check("bounce_held", 32'(key_held), 32'd0);
    exp_q.push_back(4'hF);
    pressed = kbit(3, 1);
    cyc(31);
    check("bounceF_early", 32'(key_valid), 32'd0);
    cyc(1);
    check("bounceF_valid", 32'(key_valid), 32'd1);
    check("bounceF_code", 32'(key_code), 32'hF);
    sync_frame();
    pressed = 16'h0000;
    cyc(48);
    check("bounceF_rel", 32'(key_held), 32'd0);

    // Multi-key (0,0)+(2,3) is rejected; dropping (2,3) accepts '1'.
    sync_frame();
    pressed = kbit(0, 0) | kbit(2, 3);
    cyc(48);
    check("multi_held", 32'(key_held), 32'd0);
    exp_q.push_back(4'h1);
    pressed = kbit(0, 0);
    cyc(31);
    check("multi1_early", 32'(key_valid), 32'd0);
    cyc(1);
    check("multi1_valid", 32'(key_valid), 32'd1);
    check("multi1_code", 32'(key_code), 32'h1);
    sync_frame();
    pressed = 16'h0000;
    cyc(48);

    // Release glitch on (0,3): one empty frame then re-press keeps key held.
    sync_frame();
    exp_q.push_back(4'hA);
    pressed = kbit(0, 3);
    cyc(32);
    check("glitchA_valid", 32'(key_valid), 32'd1);
    check("glitchA_code", 32'(key_code), 32'hA);
    cyc(15);
    sync_frame();
    pressed = 16'h0000;
    cyc(16);
    check("glitch_gap_held", 32'(key_held), 32'd1);
    pressed = kbit(0, 3);
    cyc(32);
    check("glitch_repress_held", 32'(key_held), 32'd1);
    pressed = 16'h0000;
    cyc(31);
    check("glitch_rel_early", 32'(key_held), 32'd1);
    cyc(1);
    check("glitch_rel_held", 32'(key_held), 32'd0);
    check("glitch_rel_code", 32'(key_code), 32'hA);

    // Reset while confirming (3,2): a full debounce is needed again for 'E'.
    sync_frame();
    pressed = kbit(3, 2);
    cyc(20);
    check("confirm_held", 32'(key_held), 32'd0);
    reset = 1'b1;
    cyc(2);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(4'hE);
    cyc(31);
    check("rstE_early", 32'(key_valid), 32'd0);
    cyc(1);
    check("rstE_valid", 32'(key_valid), 32'd1);
    check("rstE_code", 32'(key_code), 32'hE);
    sync_frame();
    pressed = 16'h0000;
    cyc(48);
    check("rstE_rel", 32'(key_held), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad on a Pmod header and reports debounced key presses. Columns are strobed one at a time, and the row lines are sampled while each column is active. This is the input counterpart of the multiplexed anode scanning used by the four-digit LED display driver. Each confirmed press produces a 4-bit hex key code and a one-cycle valid pulse, ready for the display path or a controller FSM.

## Interface
- SCAN_DIV, 1000: clk cycles each column stays active; legal range 4..65535.
- DEBOUNCE, 4: consecutive identical scan frames required to accept a press or a release; legal range 1..15.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- col  out  4  column strobes, active-low, exactly one bit low at any time.
- row  in  4  row returns, active-low, pulled up externally, asynchronous to clk.
- key_code  out  4  hex value of the last accepted key.
- key_valid  out  1  one-cycle pulse when a press is accepted.
- key_held  out  1  high from acceptance until the release is accepted.

## Operation
- **Row synchroniser:** row passes through a 2-flop synchroniser (rs) before any use.
- **Column scan:**
  - A slot counter counts 0..SCAN_DIV-1.
  - A column index counts 0..3 and wraps 3->0.
  - col = ~(4'b0001 << index).
- **Sampling and frames:**
  - On slot count SCAN_DIV-1, rs is captured into the 4-bit frame snapshot slice for the current column.
  - A frame is one pass through columns 0..3.
  - Frame end is the sample cycle of column 3.
- **Frame classification:** EMPTY (no key), SINGLE (exactly one key), MULTI (two or more keys).
- **Key legend**, row r, col c, index 0 = leftmost/topmost:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- **FSM**, evaluated only at frame end:
  - IDLE:
    - SINGLE -> CONFIRM, cnt=1, cand=key.
    - Otherwise stay in IDLE.
  - CONFIRM:
    - SINGLE with key == cand: cnt+1. If cnt+1 == DEBOUNCE -> HELD, load key_code=cand, pulse key_valid.
    - SINGLE with a different key: restart, cand=key, cnt=1.
    - EMPTY or MULTI: -> IDLE.
  - HELD:
    - EMPTY -> RELEASE, cnt=1. If DEBOUNCE==1, go directly to IDLE instead.
    - SINGLE or MULTI: stay in HELD.
  - RELEASE:
    - EMPTY: cnt+1. If cnt+1 == DEBOUNCE -> IDLE.
    - Anything else: -> HELD.
- **DEBOUNCE==1:** a SINGLE frame in IDLE goes straight to HELD with key_valid.
- **Held keys:** no auto-repeat. A key held indefinitely yields exactly one key_valid.
- **key_code:** retains the last accepted value through release and IDLE.
- **key_held:** 1 in HELD and RELEASE, 0 otherwise.

## Timing
- **Reset values:**
  - col=4'b1110, key_code=0, key_valid=0, key_held=0.
  - Slot counter, index, cnt and cand = 0; state IDLE; synchroniser flops = 4'b1111.
- **Reset assertion mid-operation:** takes effect immediately (asynchronous), whatever the state. After release the scan restarts at column 0 with a fresh frame.
- **Settling:** each column drives SCAN_DIV cycles before sampling. Effective settle time is SCAN_DIV-3 cycles after the 2-flop synchroniser.
- **Frame length:** 4*SCAN_DIV cycles.
- **key_valid timing:**
  - Registered; asserts the cycle after the accepting frame-end sample, for exactly 1 cycle.
  - key_code and key_held update on that same edge.
- **key_held deassertion:** the cycle after the DEBOUNCE-th consecutive EMPTY frame end.
- **Press latency**, from first full frame containing the key: DEBOUNCE frames + 1 cycle. Worst case from the physical press is (DEBOUNCE+1) frames + 3 cycles.
- **Column change:** col changes on the cycle after the sample cycle. Slot count wraps to 0 on the same edge.

## Test plan
Bench parameters SCAN_DIV=4 and DEBOUNCE=2 (frame = 16 cycles). The keypad model pulls row[r] low while col[c] is low and key (r,c) is pressed.
- **Reset:** assert reset mid-slot -> col=1110, key_valid=0, key_held=0, key_code=0 immediately. After release col steps 1110, 1101, 1011, 0111, 1110 every 4 cycles.
- **Single press:** press (1,1) -> after 2 full frames exactly one key_valid pulse, key_code=5, key_held=1. Hold for 10 frames -> no further pulses. Release -> key_held=0 after 2 empty frames; key_code stays 5.
- **Bounce:** press (3,1) alternating present/absent every frame for 8 frames -> no key_valid. Then hold steady -> one key_valid with key_code=F.
- **Multi-key:** press (0,0) and (2,3) together from IDLE -> no key_valid. Release (2,3) leaving (0,0) -> key_valid with key_code=1.
- **Release glitch:** while (0,3) is HELD, give 1 empty frame then press again -> key_held stays 1, no second key_valid. Then 2 empty frames -> key_held=0.
- **Reset during CONFIRM:** assert reset after the first matching frame of (3,2). After reset, a 2-frame press is needed again -> key_valid with key_code=E.
